// File: rtl/clk_rst_mon_pkg.sv
// Shared types and helpers for the clock/reset monitor.
package clk_rst_mon_pkg;

  // Monitored-reset tracking states.
  typedef enum logic [1:0] {
    WAIT_RST = 2'd0,
    IN_RST   = 2'd1,
    RUN      = 2'd2
  } rst_state_e;

  // Cycles after rst_ni release before the synchronized view and its delayed
  // copy both hold real samples (two synchronizer flops plus the edge flop).
  localparam int unsigned FillStages = 3;

  // Phase-length acceptance bound; the lower bound is clamped at zero.
  function automatic int unsigned phase_bound(input int unsigned exp_cycles,
                                              input int unsigned tol,
                                              input logic        upper);
    if (upper) begin
      return exp_cycles + tol;
    end
    return (exp_cycles > tol) ? (exp_cycles - tol) : 32'd0;
  endfunction

endpackage

// File: rtl/clk_rst_mon_sync.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module clk_rst_mon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back capture stages into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_mon.sv
// Measures the high/low phases of a monitored clock and the length of a
// monitored reset, flagging out-of-range phases and too-short resets.
module clk_rst_mon
  import clk_rst_mon_pkg::*;
#(
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned ExpHighCycles = 4,
  parameter int unsigned ExpLowCycles  = 4,
  parameter int unsigned TolCycles     = 1,
  parameter int unsigned MinRstCycles  = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mon_clk_i,
  input  logic                mon_rst_ni,
  input  logic                clr_i,
  output logic [CntWidth-1:0] high_cnt_o,
  output logic [CntWidth-1:0] low_cnt_o,
  output logic                period_valid_o,
  output logic                clk_err_o,
  output logic [CntWidth-1:0] rst_cnt_o,
  output logic                rst_err_o,
  output logic                rst_rel_o,
  output logic                in_rst_o
);

  localparam int unsigned CmpW = CntWidth + 1;

  localparam logic [CmpW-1:0] HighMin = CmpW'(phase_bound(ExpHighCycles, TolCycles, 1'b0));
  localparam logic [CmpW-1:0] HighMax = CmpW'(phase_bound(ExpHighCycles, TolCycles, 1'b1));
  localparam logic [CmpW-1:0] LowMin  = CmpW'(phase_bound(ExpLowCycles, TolCycles, 1'b0));
  localparam logic [CmpW-1:0] LowMax  = CmpW'(phase_bound(ExpLowCycles, TolCycles, 1'b1));
  localparam logic [CmpW-1:0] RstMin  = CmpW'(MinRstCycles);

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic mon_clk_s;
  logic mon_rst_s;
  logic mon_clk_d;
  logic [FillStages-1:0] fill;
  logic armed_c;
  logic rise_c;
  logic fall_c;
  logic edge_c;

  clk_rst_mon_sync u_sync_clk (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (mon_clk_i),
    .q     (mon_clk_s)
  );

  clk_rst_mon_sync u_sync_rst (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (mon_rst_ni),
    .q     (mon_rst_s)
  );

  // Delayed copy for edge detection, plus a fill marker so the zeroed
  // synchronizer contents are never mistaken for a real edge or reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mon_clk_d <= 1'b0;
      fill      <= '0;
    end else begin
      mon_clk_d <= mon_clk_s;
      fill      <= {fill[FillStages-2:0], 1'b1};
    end
  end

  assign armed_c = fill[FillStages-1];
  assign rise_c  = armed_c &  mon_clk_s & ~mon_clk_d;
  assign fall_c  = armed_c & ~mon_clk_s &  mon_clk_d;
  assign edge_c  = rise_c | fall_c;

  // ---------------------------------------------------------------------------
  // Clock phase measurement
  // ---------------------------------------------------------------------------
  logic [CntWidth-1:0] phase_cnt;
  logic [CmpW-1:0]     phase_ext_c;
  logic                phase_sat_c;
  logic                high_bad_c;
  logic                low_bad_c;
  logic                seen_edge;
  logic                have_high;

  assign phase_ext_c = CmpW'(phase_cnt);
  assign phase_sat_c = (phase_cnt == CntMax);
  assign high_bad_c  = (phase_ext_c < HighMin) || (phase_ext_c > HighMax);
  assign low_bad_c   = (phase_ext_c < LowMin)  || (phase_ext_c > LowMax);

  // Phase counter, latched measurements, validity history and sticky error.
  // The phase ending at the first edge after reset/clear is partial and dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_cnt      <= '0;
      seen_edge      <= 1'b0;
      have_high      <= 1'b0;
      high_cnt_o     <= '0;
      low_cnt_o      <= '0;
      period_valid_o <= 1'b0;
      clk_err_o      <= 1'b0;
    end else begin
      period_valid_o <= 1'b0;
      if (clr_i) begin
        phase_cnt <= '0;
        seen_edge <= 1'b0;
        have_high <= 1'b0;
        clk_err_o <= 1'b0;
      end else begin
        if (edge_c) begin
          phase_cnt <= CntOne;
          seen_edge <= 1'b1;
        end else if (!phase_sat_c) begin
          phase_cnt <= phase_cnt + 1'b1;
        end

        if (fall_c && seen_edge) begin
          high_cnt_o <= phase_cnt;
          have_high  <= 1'b1;
          if (high_bad_c) begin
            clk_err_o <= 1'b1;
          end
        end

        if (rise_c && seen_edge) begin
          low_cnt_o      <= phase_cnt;
          period_valid_o <= have_high;
          if (low_bad_c) begin
            clk_err_o <= 1'b1;
          end
        end

        if (seen_edge && phase_sat_c) begin
          clk_err_o <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitored reset tracking
  // ---------------------------------------------------------------------------
  rst_state_e          state_q;
  rst_state_e          state_d;
  logic                rst_load_c;
  logic                rst_inc_c;
  logic                rst_release_c;
  logic [CntWidth-1:0] rst_cnt;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a release is only reported after an observed assertion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_RST: if (armed_c && !mon_rst_s) state_d = IN_RST;
      IN_RST:   if (mon_rst_s)             state_d = RUN;
      RUN:      if (!mon_rst_s)            state_d = IN_RST;
      default:                             state_d = WAIT_RST;
    endcase
  end

  // Datapath controls decoded from the current and next state.
  always_comb begin
    rst_load_c    = 1'b0;
    rst_inc_c     = 1'b0;
    rst_release_c = 1'b0;
    case (state_q)
      IN_RST: begin
        if (state_d == RUN) begin
          rst_release_c = 1'b1;
        end else begin
          rst_inc_c = 1'b1;
        end
      end
      default: rst_load_c = (state_d == IN_RST);
    endcase
  end

  // Reset-length counter and registered reset outputs; clear only drops the error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_cnt   <= '0;
      rst_cnt_o <= '0;
      rst_err_o <= 1'b0;
      rst_rel_o <= 1'b0;
      in_rst_o  <= 1'b0;
    end else begin
      rst_rel_o <= rst_release_c;
      in_rst_o  <= (state_d == IN_RST);

      if (rst_load_c) begin
        rst_cnt <= CntOne;
      end else if (rst_inc_c && (rst_cnt != CntMax)) begin
        rst_cnt <= rst_cnt + 1'b1;
      end

      if (rst_release_c) begin
        rst_cnt_o <= rst_cnt;
      end

      if (clr_i) begin
        rst_err_o <= 1'b0;
      end else if (rst_release_c && (CmpW'(rst_cnt) < RstMin)) begin
        rst_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_rst_mon.sv
// Scoreboard bench for clk_rst_mon: a default instance plus a narrow-counter,
// longer-minimum-reset instance.
module tb_clk_rst_mon;

  localparam int ExpH   = 4;
  localparam int ExpL   = 4;
  localparam int Tol    = 1;
  localparam int MinRst = 1;

  typedef struct packed {
    logic [15:0] high;
    logic [15:0] low;
  } per_exp_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        err;
  } rst_exp_t;

  logic clk;
  logic rst_n;

  logic        mon_clk;
  logic        mon_rst_n;
  logic        clr;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic        period_valid;
  logic        clk_err;
  logic [15:0] rst_cnt;
  logic        rst_err;
  logic        rst_rel;
  logic        in_rst;

  logic        mon_clk_b;
  logic        mon_rst_n_b;
  logic        clr_b;
  logic [3:0]  high_cnt_b;
  logic [3:0]  low_cnt_b;
  logic        period_valid_b;
  logic        clk_err_b;
  logic [3:0]  rst_cnt_b;
  logic        rst_err_b;
  logic        rst_rel_b;
  logic        in_rst_b;

  int n_tests = 0;
  int n_fail  = 0;

  per_exp_t per_q[$];
  rst_exp_t rst_q[$];

  logic cur_lvl = 1'b0;
  int   cur_len = 0;
  int   m_high = 0;
  int   m_low  = 0;
  bit   m_seen = 1'b0;
  bit   m_have_high = 1'b0;
  bit   m_err = 1'b0;
  int   pv_count = 0;
  int   in_rst_cycles = 0;

  clk_rst_mon dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mon_clk_i      (mon_clk),
    .mon_rst_ni     (mon_rst_n),
    .clr_i          (clr),
    .high_cnt_o     (high_cnt),
    .low_cnt_o      (low_cnt),
    .period_valid_o (period_valid),
    .clk_err_o      (clk_err),
    .rst_cnt_o      (rst_cnt),
    .rst_err_o      (rst_err),
    .rst_rel_o      (rst_rel),
    .in_rst_o       (in_rst)
  );

  clk_rst_mon #(
    .CntWidth     (4),
    .MinRstCycles (3)
  ) dut_b (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mon_clk_i      (mon_clk_b),
    .mon_rst_ni     (mon_rst_n_b),
    .clr_i          (clr_b),
    .high_cnt_o     (high_cnt_b),
    .low_cnt_o      (low_cnt_b),
    .period_valid_o (period_valid_b),
    .clk_err_o      (clk_err_b),
    .rst_cnt_o      (rst_cnt_b),
    .rst_err_o      (rst_err_b),
    .rst_rel_o      (rst_rel_b),
    .in_rst_o       (in_rst_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit out_of_range(input int c, input int exp_cycles);
    return (c < exp_cycles - Tol) || (c > exp_cycles + Tol);
  endfunction

  // One clock: sample just after the edge and score any output pulses.
  task automatic step();
    per_exp_t pe;
    rst_exp_t re;
    @(posedge clk);
    #1;
    cur_len++;
    if (in_rst) in_rst_cycles++;
    if (period_valid) begin
      pv_count++;
      check_eq("pv_expected", 64'(per_q.size() != 0), 64'd1);
      if (per_q.size() != 0) begin
        pe = per_q.pop_front();
        check_eq("period_cnts", {high_cnt, low_cnt}, {pe.high, pe.low});
      end
    end
    if (rst_rel) begin
      check_eq("rel_expected", 64'(rst_q.size() != 0), 64'd1);
      if (rst_q.size() != 0) begin
        re = rst_q.pop_front();
        check_eq("rst_cnt", rst_cnt, re.cnt);
        check_eq("rst_err", rst_err, re.err);
      end
    end
  endtask

  task automatic model_clear();
    m_seen      = 1'b0;
    m_have_high = 1'b0;
    m_err       = 1'b0;
  endtask

  task automatic model_edge(input logic lvl);
    per_exp_t pe;
    if (m_seen) begin
      if (!lvl) begin
        m_high      = cur_len;
        m_have_high = 1'b1;
        if (out_of_range(cur_len, ExpH)) m_err = 1'b1;
      end else begin
        m_low = cur_len;
        if (out_of_range(cur_len, ExpL)) m_err = 1'b1;
        if (m_have_high) begin
          pe.high = 16'(m_high);
          pe.low  = 16'(m_low);
          per_q.push_back(pe);
        end
      end
    end
    m_seen  = 1'b1;
    cur_lvl = lvl;
    cur_len = 0;
  endtask

  task automatic drive_phase(input logic lvl, input int n);
    if (lvl != cur_lvl) model_edge(lvl);
    mon_clk = lvl;
    repeat (n) step();
  endtask

  task automatic drive_period(input int h, input int l);
    drive_phase(1'b1, h);
    drive_phase(1'b0, l);
  endtask

  task automatic rst_pulse(input int n);
    rst_exp_t re;
    re.cnt = 16'(n);
    re.err = (n < MinRst);
    rst_q.push_back(re);
    in_rst_cycles = 0;
    mon_rst_n = 1'b0;
    repeat (n) step();
    mon_rst_n = 1'b1;
    repeat (6) step();
    check_eq("in_rst_cycles", 64'(in_rst_cycles), 64'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {high_cnt, low_cnt, period_valid, clk_err, rst_cnt, rst_err, rst_rel, in_rst}, 64'd0);
  endtask

  initial begin
    int pv_before;
    bit seen_rel;
    rst_n       = 1'b0;
    mon_clk     = 1'b0;
    mon_rst_n   = 1'b1;
    clr         = 1'b0;
    mon_clk_b   = 1'b0;
    mon_rst_n_b = 1'b1;
    clr_b       = 1'b0;

    // Reset values.
    repeat (2) step();
    check_all_zero("reset_outs");
    check_eq("reset_outs_b", {high_cnt_b, low_cnt_b, clk_err_b, rst_cnt_b, rst_err_b, in_rst_b}, 64'd0);
    rst_n = 1'b1;
    repeat (6) step();
    check_eq("wait_rst_no_in_rst", 64'(in_rst), 64'd0);

    // Monitored reset: 5 cycles from WAIT_RST, then a 3-cycle re-reset in RUN.
    rst_pulse(5);
    check_eq("rst_cnt_5", 64'(rst_cnt), 64'd5);
    rst_pulse(3);
    check_eq("rst_cnt_3", 64'(rst_cnt), 64'd3);
    check_eq("rst_err_min1", 64'(rst_err), 64'd0);

    // Ten nominal periods.
    pv_count = 0;
    repeat (10) drive_period(4, 4);
    check_eq("pv_count_10per", 64'(pv_count), 64'd9);
    check_eq("high_cnt_nom", 64'(high_cnt), 64'd4);
    check_eq("low_cnt_nom", 64'(low_cnt), 64'd4);
    check_eq("clk_err_nom", 64'(clk_err), 64'd0);

    // Phases exactly at the tolerance bounds.
    drive_period(5, 3);
    drive_period(3, 5);
    drive_period(4, 4);
    check_eq("clk_err_tol_edge", 64'(clk_err), 64'(m_err));
    check_eq("clk_err_tol_edge_zero", 64'(clk_err), 64'd0);

    // Single over-long high phase sets the sticky error until cleared.
    drive_period(6, 4);
    check_eq("clk_err_long_high", 64'(clk_err), 64'd1);
    check_eq("high_cnt_6", 64'(high_cnt), 64'd6);
    repeat (2) drive_period(4, 4);
    check_eq("clk_err_sticky", 64'(clk_err), 64'(m_err));
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    check_eq("clk_err_cleared", 64'(clk_err), 64'd0);
    check_eq("rst_cnt_kept_by_clr", 64'(rst_cnt), 64'd3);

    // Clear coinciding with an out-of-range falling edge.
    drive_phase(1'b0, 2);
    repeat (2) drive_period(4, 4);
    drive_phase(1'b1, 6);
    mon_clk = 1'b0;
    cur_lvl = 1'b0;
    cur_len = 0;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_clear();
    pv_before = pv_count;
    check_eq("clr_edge_no_err", 64'(clk_err), 64'd0);
    check_eq("clr_edge_no_latch", 64'(high_cnt), 64'd4);
    drive_phase(1'b0, 4);
    drive_phase(1'b1, 4);
    drive_phase(1'b0, 4);
    check_eq("clr_edge_no_pulse", 64'(pv_count), 64'(pv_before));
    check_eq("clr_edge_err_after", 64'(clk_err), 64'd0);

    // rst_ni in the middle of a high phase.
    drive_phase(1'b1, 5);
    rst_n = 1'b0;
    step();
    check_all_zero("midphase_rst_outs");
    step();
    step();
    rst_n = 1'b1;
    model_clear();
    drive_phase(1'b1, 4);
    drive_phase(1'b0, 4);
    check_eq("no_latch_after_rst", 64'(high_cnt), 64'd0);
    repeat (3) drive_period(4, 4);
    check_eq("high_cnt_after_rst", 64'(high_cnt), 64'd4);
    check_eq("clk_err_after_rst", 64'(clk_err), 64'(m_err));

    // Narrow instance: too-short reset against MinRstCycles=3.
    repeat (4) step();
    mon_rst_n_b = 1'b0;
    repeat (2) step();
    mon_rst_n_b = 1'b1;
    seen_rel = 1'b0;
    for (int i = 0; i < 10 && !seen_rel; i++) begin
      step();
      if (rst_rel_b) seen_rel = 1'b1;
    end
    check_eq("rst_rel_b_seen", 64'(seen_rel), 64'd1);
    check_eq("rst_cnt_b_2", 64'(rst_cnt_b), 64'd2);
    check_eq("rst_err_b_short", 64'(rst_err_b), 64'd1);

    // Narrow instance: stuck-high clock saturates the 4-bit counter.
    mon_clk_b = 1'b1;
    repeat (10) step();
    check_eq("clk_err_b_pre_sat", 64'(clk_err_b), 64'd0);
    repeat (15) step();
    check_eq("clk_err_b_sat", 64'(clk_err_b), 64'd1);
    check_eq("high_cnt_b_none", 64'(high_cnt_b), 64'd0);
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check_eq("clr_b_errs", {62'd0, clk_err_b, rst_err_b}, 64'd0);
    check_eq("clr_b_rst_cnt_kept", 64'(rst_cnt_b), 64'd2);
    repeat (20) step();
    check_eq("clk_err_b_no_edge", 64'(clk_err_b), 64'd0);

    check_eq("per_q_drained", 64'(per_q.size()), 64'd0);
    check_eq("rst_q_drained", 64'(rst_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
